// File: rtl/regfile_multiport_pkg.sv
// Shared CPU package: register file defaults and the clear-sequencer state encoding.
package regfile_multiport_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every register index once, one per cycle, on request or reset.
module regfile_clear_fsm
  import regfile_multiport_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          busy,
  output logic [AW-1:0] clr_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (reset) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
          end
        end
        CLEAR: begin
          // Requests are ignored here; the sweep always runs exactly NREG cycles.
          clr_idx_d = clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NREG - 1)) state_d = IDLE;
        end
        default: state_d = CLEAR;
      endcase
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    busy_q    <= busy_d;
  end

  assign busy    = busy_q;
  assign clr_idx = clr_idx_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, dual-write register file with x0 hardwired to zero, write-through
// bypass, and a sequenced full-array clear.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                clear_req,
  output logic                busy
);

  logic [XLEN-1:0] mem [NREG];
  logic [AW-1:0]   clr_idx;
  logic            rd_block;
  logic            clr_we;
  logic            we0_ok, we1_ok, we0_commit;

  regfile_clear_fsm #(.NREG(NREG)) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_idx   (clr_idx)
  );

  // Write ports are locked out during reset and clear; address 0 is never stored.
  assign rd_block   = busy || reset;
  assign clr_we     = busy && !reset;
  assign we0_ok     = we0 && !rd_block && (wa0 != '0);
  assign we1_ok     = we1 && !rd_block && (wa1 != '0);
  assign we0_commit = we0_ok && !(we1_ok && (wa1 == wa0));

  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_idx] <= '0;
    if (we0_commit) mem[wa0]     <= wd0;
    if (we1_ok)     mem[wa1]     <= wd1;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = rd_addr[k*AW +: AW];

    // Port 1 is applied last so it wins a same-address collision on the bypass.
    always_comb begin
      rv = mem[ra];
      if (ra == '0)               rv = '0;
      if (we0_ok && (wa0 == ra))  rv = wd0;
      if (we1_ok && (wa1 == ra))  rv = wd1;
      if (rd_block)               rv = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = rv;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios plus random traffic against an array model.
module tb_regfile_multiport;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic                clear_req;
  logic                busy;

  regfile_multiport #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .we0       (we0),
    .wa0       (wa0),
    .wd0       (wd0),
    .we1       (we1),
    .wa1       (wa1),
    .wd1       (wd1),
    .clear_req (clear_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int              total = 0;
  int              bad   = 0;
  logic [XLEN-1:0] model [NREG];
  int              busy_left = 0;
  bit              started   = 1'b0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view: zero while resetting/clearing or for x0, newest write visible at once.
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (reset || busy_left > 0 || a == '0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return model[a];
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; clear_req = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Check outputs mid-cycle, take one clock edge, advance the model, return at negedge.
  task automatic cycle();
    #1;
    if (started) begin
      check("busy", 64'(busy), 64'(busy_left > 0));
      for (int k = 0; k < NRD; k++)
        check($sformatf("rd%0d", k), rd_data[k*XLEN +: XLEN], exp_rd(rd_addr[k*AW +: AW]));
    end
    @(posedge clk);
    if (reset) begin
      busy_left = NREG;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0)
        for (int i = 0; i < NREG; i++) model[i] = '0;
    end else if (clear_req) begin
      busy_left = NREG;
    end else begin
      if (we0 && wa0 != '0) model[wa0] = wd0;
      if (we1 && wa1 != '0) model[wa1] = wd1;
    end
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_busy(output int n, input bool_inject);
    n = 0;
    while (busy && n < 100) begin
      we0       = (bool_inject != 0) && (n == 3);
      wa0       = AW'(9);
      wd0       = 64'h0ABC;
      clear_req = (bool_inject != 0) && (n == 10);
      cycle();
      n++;
    end
    idle_inputs();
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < NREG; i++) begin
      set_rd(i, NREG - 1 - i);
      #1 check(tag, rd_data[0 +: XLEN], '0);
      cycle();
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;
    idle_inputs();
    set_rd(0, 0);

    // Power-up reset for one cycle, then the automatic clear sweep.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("busy_after_reset", 64'(busy), 64'd1);
    drain_busy(n, 0);
    check("reset_busy_len", 64'(n), 64'(NREG));
    sweep_zero("post_reset_zero");

    // Bypass then stored value.
    we0 = 1'b1; wa0 = AW'(5); wd0 = 64'hDEAD_BEEF; set_rd(5, 0);
    #1 check("bypass_w0", rd_data[0 +: XLEN], 64'hDEAD_BEEF);
    cycle();
    idle_inputs();
    #1 check("stored_w0", rd_data[0 +: XLEN], 64'hDEAD_BEEF);
    cycle();

    // Same-address collision: port 1 wins.
    we0 = 1'b1; wa0 = AW'(7); wd0 = 64'h11;
    we1 = 1'b1; wa1 = AW'(7); wd1 = 64'h22; set_rd(7, 7);
    #1 check("collide_bypass", rd_data[XLEN +: XLEN], 64'h22);
    cycle();
    idle_inputs();
    repeat (3) begin
      #1 check("collide_stored", rd_data[0 +: XLEN], 64'h22);
      cycle();
    end

    // Writes to x0 are discarded.
    we1 = 1'b1; wa1 = '0; wd1 = 64'hFFFF; set_rd(5, 0);
    #1 check("x0_bypass", rd_data[XLEN +: XLEN], '0);
    cycle();
    idle_inputs();
    #1 check("x0_stored", rd_data[XLEN +: XLEN], '0);
    cycle();

    // Fill, clear with a lost write and an ignored second request.
    for (int i = 1; i < NREG; i++) begin
      we0 = 1'b1; wa0 = AW'(i); wd0 = 64'(i); set_rd(i, i - 1);
      cycle();
    end
    idle_inputs();
    set_rd(17, 31);
    #1 check("filled_17", rd_data[0 +: XLEN], 64'd17);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    check("clear_busy_rise", 64'(busy), 64'd1);
    drain_busy(n, 1);
    check("clear_busy_len", 64'(n), 64'(NREG));
    sweep_zero("post_clear_zero");

    // Reset during a clear restarts the sweep.
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (14) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("reset_in_clear_busy", 64'(busy), 64'd1);
    drain_busy(n, 0);
    check("reset_in_clear_len", 64'(n), 64'(NREG));

    // Random traffic; read addresses often track write addresses to hit the bypass.
    repeat (600) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear_req = ($urandom_range(0, 79) == 0);
      we0 = $urandom_range(0, 1) == 1; wa0 = AW'($urandom_range(0, NREG - 1));
      we1 = $urandom_range(0, 1) == 1; wa1 = AW'($urandom_range(0, NREG - 1));
      wd0 = {$urandom, $urandom};
      wd1 = {$urandom, $urandom};
      set_rd(($urandom_range(0, 2) == 0) ? int'(wa0) : int'($urandom_range(0, NREG - 1)),
             ($urandom_range(0, 2) == 0) ? int'(wa1) : int'($urandom_range(0, NREG - 1)));
      cycle();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
